// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg
//   Shared definitions for the partial-sum accumulator.
//   - FSM state encoding (IDLE / ACCUM / DRAIN)
//   - Default array geometry (columns, lane width, bank depth)
package psum_accum_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 16;
    localparam int ADDR_BW_DEF = 4;
    localparam int PASS_BW     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/psum_accum_bank.sv
// psum_bank
//   depth x (col*psum_bw) register file holding one pass worth of partial
//   sums. One synchronous write port, two combinational read ports.
//   Ports:
//     clk        - clock
//     we         - write enable
//     waddr      - write address
//     wdata      - write data (full vector)
//     acc_raddr  - accumulate read address   -> acc_rdata
//     drn_raddr  - drain read address        -> drn_rdata
//   No reset: the first accumulation pass always overwrites every live entry.
module psum_bank #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16,
    parameter int addr_bw = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [addr_bw-1:0]       waddr,
    input  logic [col*psum_bw-1:0]   wdata,
    input  logic [addr_bw-1:0]       acc_raddr,
    output logic [col*psum_bw-1:0]   acc_rdata,
    input  logic [addr_bw-1:0]       drn_raddr,
    output logic [col*psum_bw-1:0]   drn_rdata
);

    logic [col*psum_bw-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign acc_rdata = mem_q[acc_raddr];
    assign drn_rdata = mem_q[drn_raddr];

endmodule

// File: rtl/psum_accum.sv
// psum_accum
//   Accumulates num_pass passes of num_vec output vectors popped from the
//   OFIFO into a local bank, then drains the ReLU'd result downstream.
//   Ports:
//     clk, reset            - clock, synchronous active-high reset
//     start                 - job launch (IDLE only), with num_vec / num_pass
//     in_data/in_valid/in_rd - OFIFO head vector, non-empty flag, pop
//     out_data/out_valid/out_ready - drained result handshake
//     busy                  - not IDLE
//     done                  - pulse on the final output transfer
//
//   state | meaning
//   IDLE  | waiting for a legal start
//   ACCUM | popping OFIFO vectors and summing them into the bank
//   DRAIN | presenting ReLU(bank[out_addr]) until all vectors transfer
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF,
    parameter int addr_bw = ADDR_BW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw:0]         num_vec,
    input  logic [PASS_BW-1:0]       num_pass,
    input  logic [col*psum_bw-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_rd,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int NV_W = addr_bw + 1;

    state_e               state_q, state_d;
    logic [addr_bw-1:0]   addr_q, addr_d;
    logic [PASS_BW-1:0]   pass_q, pass_d;
    logic [addr_bw-1:0]   out_addr_q, out_addr_d;
    logic [NV_W-1:0]      num_vec_q, num_vec_d;
    logic [PASS_BW-1:0]   num_pass_q, num_pass_d;

    logic                 start_ok;
    logic                 last_addr, last_pass, last_out;
    logic [col*psum_bw-1:0] acc_rdata, drn_rdata, wr_data;

    assign start_ok  = start && (num_vec != '0) && (num_vec <= NV_W'(depth))
                       && (num_pass != '0);
    assign last_addr = ({1'b0, addr_q} == (num_vec_q - NV_W'(1)));
    assign last_pass = (pass_q == (num_pass_q - PASS_BW'(1)));
    assign last_out  = ({1'b0, out_addr_q} == (num_vec_q - NV_W'(1)));

    // Outputs are masked during reset so an aborted job cannot pop or emit
    // in the reset cycle itself.
    assign in_rd     = !reset && (state_q == ACCUM) && in_valid;
    assign out_valid = !reset && (state_q == DRAIN);
    assign busy      = !reset && (state_q != IDLE);
    assign done      = out_valid && out_ready && last_out;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        out_addr_d = out_addr_q;
        num_vec_d  = num_vec_q;
        num_pass_d = num_pass_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = ACCUM;
                    addr_d     = '0;
                    pass_d     = '0;
                    out_addr_d = '0;
                    num_vec_d  = num_vec;
                    num_pass_d = num_pass;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (last_addr) begin
                        addr_d = '0;
                        pass_d = pass_q + PASS_BW'(1);
                        if (last_pass) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + addr_bw'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    out_addr_d = out_addr_q + addr_bw'(1);
                    if (last_out) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            out_addr_q <= '0;
            num_vec_q  <= '0;
            num_pass_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            out_addr_q <= out_addr_d;
            num_vec_q  <= num_vec_d;
            num_pass_q <= num_pass_d;
        end
    end

    // Pass 0 overwrites so stale bank contents never leak into a new job;
    // later passes add lane-wise with natural two's-complement wrap.
    always_comb begin
        wr_data = '0;
        for (int k = 0; k < col; k++) begin
            if (pass_q == '0) begin
                wr_data[k*psum_bw +: psum_bw] = in_data[k*psum_bw +: psum_bw];
            end else begin
                wr_data[k*psum_bw +: psum_bw] = acc_rdata[k*psum_bw +: psum_bw]
                                              + in_data[k*psum_bw +: psum_bw];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < col; k++) begin
            if (!drn_rdata[k*psum_bw + psum_bw - 1]) begin
                out_data[k*psum_bw +: psum_bw] = drn_rdata[k*psum_bw +: psum_bw];
            end
        end
    end

    psum_bank #(
        .col     (col),
        .psum_bw (psum_bw),
        .depth   (depth),
        .addr_bw (addr_bw)
    ) u_bank (
        .clk       (clk),
        .we        (in_rd),
        .waddr     (addr_q),
        .wdata     (wr_data),
        .acc_raddr (addr_q),
        .acc_rdata (acc_rdata),
        .drn_raddr (out_addr_q),
        .drn_rdata (drn_rdata)
    );

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum
//   Self-checking bench for psum_accum. Expected vectors come from a plain
//   integer model: per output vector, sum the lanes of all passes, wrap to
//   16 bits, clamp negatives to zero.
module tb_psum_accum;

    localparam int COL = 8, BW = 16, DEPTH = 16, ABW = 4, W = COL * BW;
    typedef logic [W-1:0] vec_t;

    logic         clk = 1'b0;
    logic         reset, start, in_valid, out_ready;
    logic [ABW:0] num_vec;
    logic [3:0]   num_pass;
    vec_t         in_data, out_data;
    logic         in_rd, out_valid, busy, done;

    psum_accum #(.col(COL), .psum_bw(BW), .depth(DEPTH), .addr_bw(ABW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
        .num_pass(num_pass), .in_data(in_data), .in_valid(in_valid),
        .in_rd(in_rd), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int   n_checks = 0, n_pass = 0;
    vec_t in_q[$], out_q[$], exp_q[$];
    int   rd_count, done_count, stab_err, rd_err, first_ov, last_pop;
    bit   timeout, done_last, started_busy;

    function automatic vec_t splat(input int v);
        vec_t r;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = v[BW-1:0];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: out[v] lane k = relu(wrap16(sum_p in[p*nv+v] lane k))
    task automatic model_job(input int nv, input int np);
        exp_q.delete();
        for (int v = 0; v < nv; v++) begin
            vec_t e;
            for (int k = 0; k < COL; k++) begin
                int s;
                logic signed [BW-1:0] lv, t;
                s = 0;
                for (int p = 0; p < np; p++) begin
                    lv = in_q[p*nv + v][k*BW +: BW];
                    s += int'(lv);
                end
                t = s[BW-1:0];
                e[k*BW +: BW] = (t < 0) ? '0 : t;
            end
            exp_q.push_back(e);
        end
    endtask

    // Drives one job from a negedge; returns in the first IDLE cycle after done.
    task automatic run_job(input int nv, input int np, input int vpct,
                           input int rpct, input bit det, input bit noisy);
        int   idx, cyc, drain_cyc;
        bit   fin, hold;
        vec_t prev;
        out_q.delete();
        rd_count = 0; done_count = 0; stab_err = 0; rd_err = 0;
        first_ov = -1; last_pop = -1; timeout = 0; done_last = 0;
        start = 1; num_vec = 5'(nv); num_pass = 4'(np); in_valid = 0; out_ready = 0;
        @(negedge clk);
        start = 0;
        #1 started_busy = busy;
        idx = 0; cyc = 0; drain_cyc = 0; fin = 0; hold = 0; prev = '0;
        while (!fin) begin
            if (cyc >= 3000) begin timeout = 1; break; end
            if (noisy) begin
                start    = 1'($urandom_range(1));
                num_vec  = 5'($urandom_range(16, 1));
                num_pass = 4'($urandom_range(15, 1));
            end
            in_valid  = det ? (cyc % 2 == 0) : ($urandom_range(99) < vpct);
            in_data   = (idx < in_q.size()) ? in_q[idx] : rand_vec();
            out_ready = det ? !(drain_cyc >= 1 && drain_cyc <= 3)
                            : ($urandom_range(99) < rpct);
            #1;
            if (in_rd && (!in_valid || out_valid)) rd_err++;
            if (in_rd) begin rd_count++; idx++; last_pop = cyc; end
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (hold && out_data !== prev) stab_err++;
                hold = !out_ready;
                prev = out_data;
                drain_cyc++;
                if (out_ready) out_q.push_back(out_data);
            end
            if (done) begin
                done_count++;
                done_last = out_valid && out_ready && (out_q.size() == nv);
                fin = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; start = 1; num_vec = 5'd1; num_pass = 4'd1;
        in_valid = 1; out_ready = 1; in_data = splat(1);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, in_rd, out_valid, done} !== 4'b0000)
            $display("FAIL reset_outputs busy/in_rd/out_valid/done=%b required 0000",
                     {busy, in_rd, out_valid, done});
        else n_pass++;
        @(negedge clk);
        reset = 0; start = 0; in_valid = 0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_priority busy=%b required 0", busy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        in_q.delete(); in_q.push_back(splat(5)); in_q.push_back(splat(-3));
        run_job(2, 1, 100, 100, 0, 0);
        n_checks++;
        if (out_q.size() != 2) $display("FAIL basic_count got %0d required 2", out_q.size());
        else begin
            n_pass++;
            n_checks++;
            if (out_q[0] !== splat(5)) $display("FAIL basic_v0 got %h required %h", out_q[0], splat(5));
            else n_pass++;
            n_checks++;
            if (out_q[1] !== splat(0)) $display("FAIL basic_v1 got %h required %h", out_q[1], splat(0));
            else n_pass++;
        end
        n_checks++;
        if (done_count != 1 || !done_last)
            $display("FAIL basic_done count=%0d on_last=%0d required 1/1", done_count, done_last);
        else n_pass++;
        n_checks++;
        if (first_ov - last_pop != 1)
            $display("FAIL basic_latency got %0d required 1", first_ov - last_pop);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL basic_idle busy=%b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_multi_pass();
        in_q.delete(); in_q.push_back(splat(100)); in_q.push_back(splat(-40)); in_q.push_back(splat(7));
        run_job(1, 3, 100, 100, 0, 0);
        n_checks++;
        if (out_q.size() != 1 || out_q[0] !== splat(67))
            $display("FAIL multi_pass_result got n=%0d v=%h required n=1 v=%h",
                     out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, splat(67));
        else n_pass++;
        n_checks++;
        if (rd_count != 3) $display("FAIL multi_pass_pops got %0d required 3", rd_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        in_q.delete(); in_q.push_back(splat(32767)); in_q.push_back(splat(1));
        run_job(1, 2, 100, 100, 0, 0);
        n_checks++;
        if (out_q.size() != 1 || out_q[0] !== splat(0))
            $display("FAIL wrap_relu got n=%0d v=%h required n=1 v=%h",
                     out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, splat(0));
        else n_pass++;
    endtask

    task automatic test_stall();
        in_q.delete();
        for (int i = 0; i < 8; i++) in_q.push_back(rand_vec());
        model_job(4, 2);
        run_job(4, 2, 0, 0, 1, 0);
        n_checks++;
        if (out_q.size() != 4 || timeout) $display("FAIL stall_count got %0d required 4", out_q.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (out_q[i] !== exp_q[i]) $display("FAIL stall_v%0d got %h required %h", i, out_q[i], exp_q[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (stab_err != 0 || rd_err != 0 || rd_count != 8)
            $display("FAIL stall_hold unstable=%0d bad_rd=%0d pops=%0d required 0/0/8", stab_err, rd_err, rd_count);
        else n_pass++;
        n_checks++;
        if (first_ov - last_pop != 1) $display("FAIL stall_latency got %0d required 1", first_ov - last_pop);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int bad;
        start = 1; num_vec = 5'd2; num_pass = 4'd2;
        @(negedge clk);
        start = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin in_data = rand_vec(); @(negedge clk); end
        reset = 1; in_data = rand_vec();
        #1;
        n_checks++;
        if (in_rd !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_reset_cycle in_rd=%b busy=%b required 0/0", in_rd, busy);
        else n_pass++;
        @(negedge clk);
        reset = 0; out_ready = 1;
        bad = 0;
        repeat (4) begin
            #1 if (in_rd || out_valid || busy || done) bad++;
            @(negedge clk);
        end
        in_valid = 0; out_ready = 0;
        n_checks++;
        if (bad != 0) $display("FAIL abort_quiet got %0d active cycles required 0", bad);
        else n_pass++;
        in_q.delete(); in_q.push_back(splat(9));
        run_job(1, 1, 100, 100, 0, 0);
        n_checks++;
        if (out_q.size() != 1 || out_q[0] !== splat(9))
            $display("FAIL abort_fresh got n=%0d v=%h required n=1 v=%h",
                     out_q.size(), (out_q.size() > 0) ? out_q[0] : '0, splat(9));
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int nvs[3] = '{0, 17, 4};
        int nps[3] = '{1, 1, 0};
        for (int c = 0; c < 3; c++) begin
            start = 1; num_vec = 5'(nvs[c]); num_pass = 4'(nps[c]); in_valid = 1;
            @(negedge clk);
            start = 0;
            #1;
            n_checks++;
            if (busy !== 1'b0 || in_rd !== 1'b0)
                $display("FAIL ignore_illegal_%0d busy=%b in_rd=%b required 0/0", c, busy, in_rd);
            else n_pass++;
            @(negedge clk);
        end
        in_valid = 0;
        in_q.delete();
        for (int i = 0; i < 6; i++) in_q.push_back(rand_vec());
        model_job(3, 2);
        run_job(3, 2, 70, 60, 0, 1);
        n_checks++;
        if (out_q.size() != 3 || rd_count != 6)
            $display("FAIL ignore_busy_count outs=%0d pops=%0d required 3/6", out_q.size(), rd_count);
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (out_q[i] !== exp_q[i]) $display("FAIL ignore_busy_v%0d got %h required %h", i, out_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 2; j++) begin
            int nv, np;
            nv = $urandom_range(DEPTH, 1);
            np = $urandom_range(4, 1);
            in_q.delete();
            for (int i = 0; i < nv * np; i++) in_q.push_back(rand_vec());
            model_job(nv, np);
            run_job(nv, np, 100, 100, 0, 0);
            n_checks++;
            if (!started_busy) $display("FAIL b2b_accept_%0d busy=0 required 1", j);
            else n_pass++;
            n_checks++;
            if (out_q.size() != nv || done_count != 1 || !done_last)
                $display("FAIL b2b_count_%0d outs=%0d done=%0d required %0d/1", j, out_q.size(), done_count, nv);
            else begin
                int bad;
                n_pass++;
                bad = 0;
                for (int i = 0; i < nv; i++) if (out_q[i] !== exp_q[i]) bad++;
                n_checks++;
                if (bad != 0) $display("FAIL b2b_data_%0d got %0d wrong vectors required 0", j, bad);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            int nv, np, bad;
            nv = $urandom_range(DEPTH, 1);
            np = $urandom_range(15, 1);
            in_q.delete();
            for (int i = 0; i < nv * np; i++) in_q.push_back(rand_vec());
            model_job(nv, np);
            run_job(nv, np, $urandom_range(100, 30), $urandom_range(100, 30), 0, 1);
            n_checks++;
            if (timeout || out_q.size() != nv || rd_count != nv * np || done_count != 1)
                $display("FAIL rand_shape_%0d to=%0d outs=%0d pops=%0d done=%0d required 0/%0d/%0d/1",
                         j, timeout, out_q.size(), rd_count, done_count, nv, nv * np);
            else n_pass++;
            bad = 0;
            for (int i = 0; i < nv && i < out_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
            n_checks++;
            if (bad != 0 || stab_err != 0 || rd_err != 0)
                $display("FAIL rand_data_%0d wrong=%0d unstable=%0d bad_rd=%0d required 0/0/0",
                         j, bad, stab_err, rd_err);
            else n_pass++;
            n_checks++;
            if (first_ov - last_pop != 1)
                $display("FAIL rand_latency_%0d got %0d required 1", j, first_ov - last_pop);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1; start = 0; num_vec = '0; num_pass = '0;
        in_data = '0; in_valid = 0; out_ready = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_multi_pass();
        test_wrap();
        test_stall();
        test_reset_abort();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 Parameters: col, 8, MAC array columns (lanes per vector); psum_bw, 16, signed lane width; depth, 16, output vectors per pass; addr_bw, 4, log2(depth).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle job launch, sampled only in IDLE.
REQ-005 num_vec  input  addr_bw+1  vectors per pass, legal 1..depth, sampled with start.
REQ-006 num_pass  input  4  accumulation passes (kernel positions), legal 1..15, sampled with start.
REQ-007 in_data  input  col*psum_bw  OFIFO head vector; lane k occupies bits [k*psum_bw +: psum_bw].
REQ-008 in_valid  input  1  OFIFO holds at least one vector (show-ahead head on in_data).
REQ-009 in_rd  output  1  OFIFO pop; in_data is consumed in the same cycle.
REQ-010 out_data  output  col*psum_bw  ReLU-applied accumulated vector.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-cycle pulse on completion of the final output transfer.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and DRAIN.
- IDLE->ACCUM on start with num_vec in 1..depth and num_pass in 1..15.
- Any other start value: ignored; remain IDLE.
REQ-016 Start SHALL latch num_vec and num_pass and clear addr, pass and out_addr counters to 0.
REQ-017 in_rd SHALL equal (state==ACCUM && in_valid), combinationally; in_rd SHALL never be high in IDLE or DRAIN.
REQ-018 On each cycle with in_rd=1, bank[addr] lane k SHALL be written.
- pass 0: written with in_data lane k (overwrite).
- pass >0: written with bank[addr] lane k + in_data lane k, signed, wrapping modulo 2^psum_bw, no saturation.
REQ-019 After each pop, addr SHALL increment.
- At addr==num_vec-1: addr wraps to 0 and pass increments.
- At addr==num_vec-1 in pass num_pass-1: next state is DRAIN.
REQ-020 Cycles in ACCUM with in_valid=0 SHALL hold all counters and bank contents (stall).
REQ-021 In DRAIN, out_valid SHALL be 1, and out_data lane k SHALL equal max(bank[out_addr] lane k, 0) as signed.
REQ-022 A DRAIN cycle with out_ready=1 is a transfer; out_addr SHALL increment on each transfer.
- With out_ready=0: out_addr and out_data held stable.
REQ-023 The transfer at out_addr==num_vec-1 SHALL pulse done in that same cycle and return the FSM to IDLE on the next edge.
REQ-024 Back-to-back jobs: a start in the first IDLE cycle after done SHALL be accepted.
REQ-025 The latency from the last pop to the first out_valid SHALL be exactly 1 cycle.
REQ-026 Bank entries at addr>=num_vec SHALL be left unmodified.

Reset
REQ-027 Reset SHALL force state IDLE; addr, pass and out_addr = 0; in_rd=0, out_valid=0, busy=0, done=0.
REQ-028 Reset during ACCUM or DRAIN SHALL abort the job with no further pops or outputs.
- Bank contents need no reset, because pass 0 overwrites them.
REQ-029 Reset SHALL take priority over start in the same cycle.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding (IDLE=0, ACCUM=1, DRAIN=2) and the default col/psum_bw/depth constants.
REQ-031 Storage SHALL be a sub-module psum_bank with the following ports:
- depth x (col*psum_bw) register file;
- one synchronous write port;
- two combinational read ports (accumulate read, drain read).

Verification
REQ-032 num_vec=2, num_pass=1, in_valid high, inputs all-lanes 5 then -3 -> out vectors all-lanes 5 then 0; done on 2nd transfer.
REQ-033 num_vec=1, num_pass=3, inputs 100, -40, 7 -> single output all-lanes 67; exactly 3 in_rd pulses.
REQ-034 Wrap check: num_pass=2, lane inputs 32767 then 1 -> sum -32768 -> ReLU output 0.
REQ-035 in_valid toggling 1-0-1 and out_ready low for 3 cycles mid-drain -> counters stall, out_data stable, results unchanged versus no-stall run.
REQ-036 Reset asserted in pass 1 of num_pass=2, then a fresh job with num_vec=1, num_pass=1, input 9 -> output 9, with no residue from the aborted job.
REQ-037 start with num_vec=0, or start while busy -> ignored: busy unchanged, no in_rd.
